// File: rtl/ex_stage.sv
// Execute stage: latches the decode bus under a valid/allowin handshake,
// produces a single-cycle ALU / multiplier result or runs a multi-cycle
// restoring unsigned divider, and drives the EX->MEM and forwarding buses.
module ex_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 15,
  parameter int DS_W = 16 + OP_W + 3*XLEN,
  parameter int MS_W = 16 + 2*XLEN
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            ds_to_es_valid,
  input  logic [DS_W-1:0] ds_es_bus,
  output logic            es_allowin,
  input  logic            ms_allowin,
  output logic            es_to_ms_valid,
  output logic [MS_W-1:0] es_ms_bus,
  output logic            es_fwd_we,
  output logic [4:0]      es_fwd_rd,
  output logic [XLEN-1:0] es_fwd_data,
  output logic            es_busy
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  logic            es_valid;
  logic [DS_W-1:0] bus_r;
  logic            es_ready_go;

  // Decode bus fields
  logic [10:0]     ctl;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] st_data;
  logic [4:0]      rd;
  logic            reg_write;
  logic            is_div;

  assign rd        = bus_r[4:0];
  assign st_data   = bus_r[5 +: XLEN];
  assign data2     = bus_r[5+XLEN +: XLEN];
  assign data1     = bus_r[5+2*XLEN +: XLEN];
  assign op        = bus_r[5+3*XLEN +: OP_W];
  assign ctl       = bus_r[DS_W-1 -: 11];
  assign reg_write = ctl[8];
  assign is_div    = op[13] | op[14];

  // Divider state
  div_state_t      state, state_next;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  assign rem_sh = {rem_r, quo_r[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_r};

  // Handshake
  assign es_ready_go    = is_div ? (state == DONE) : 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  // Pipeline register: flush drops both the held and the incoming instruction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid <= 1'b0;
      bus_r    <= '0;
    end else if (flush) begin
      es_valid <= 1'b0;
    end else if (ds_to_es_valid && es_allowin) begin
      es_valid <= 1'b1;
      bus_r    <= ds_es_bus;
    end else if (es_allowin) begin
      es_valid <= 1'b0;
    end
  end

  // Divider FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Divider FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (es_valid && is_div) state_next = RUN;
      RUN:     if (cnt_r == CNT_W'(XLEN-1)) state_next = DONE;
      DONE:    if (es_to_ms_valid && ms_allowin) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Divider datapath: load operands, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else begin
      case (state)
        IDLE: if (state_next == RUN) begin
          quo_r <= data1;
          rem_r <= '0;
          dvs_r <= data2;
          cnt_r <= '0;
        end
        RUN: begin
          quo_r <= {quo_r[XLEN-2:0], ~diff[XLEN]};
          rem_r <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          cnt_r <= cnt_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Single-cycle ALU and multiplier
  logic [SH_W-1:0]   shamt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result;

  assign shamt = data2[SH_W-1:0];
  assign prod  = {{XLEN{1'b0}}, data1} * {{XLEN{1'b0}}, data2};

  // Result select: OR of the outputs selected by the one-hot op
  always_comb begin
    result = '0;
    if (op[0])  result = result | (data1 + data2);
    if (op[1])  result = result | (data1 - data2);
    if (op[2])  result = result | (data1 & data2);
    if (op[3])  result = result | (data1 | data2);
    if (op[4])  result = result | (data1 ^ data2);
    if (op[5])  result = result | (data1 << shamt);
    if (op[6])  result = result | (data1 >> shamt);
    if (op[7])  result = result | XLEN'($signed(data1) >>> shamt);
    if (op[8])  result = result | {{(XLEN-1){1'b0}}, $signed(data1) < $signed(data2)};
    if (op[9])  result = result | {{(XLEN-1){1'b0}}, data1 < data2};
    if (op[10]) result = result | data2;
    if (op[11]) result = result | prod[XLEN-1:0];
    if (op[12]) result = result | prod[2*XLEN-1:XLEN];
    if (op[13]) result = result | quo_r;
    if (op[14]) result = result | rem_r;
  end

  assign es_ms_bus   = {ctl, result, st_data, rd};
  assign es_fwd_we   = es_valid && reg_write && es_ready_go;
  assign es_fwd_rd   = rd;
  assign es_fwd_data = result;
  assign es_busy     = es_valid && reg_write && !es_ready_go;

endmodule

// File: tb/tb_ex_stage.sv
// Directed, scoreboard-driven bench for the execute stage.
module tb_ex_stage;

  localparam int XLEN = 32;
  localparam int OP_W = 15;
  localparam int DS_W = 16 + OP_W + 3*XLEN;
  localparam int MS_W = 16 + 2*XLEN;
  localparam logic [10:0] CTL = 11'b001_0010_010_0;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic            ds_to_es_valid;
  logic [DS_W-1:0] ds_es_bus;
  logic            es_allowin;
  logic            ms_allowin;
  logic            es_to_ms_valid;
  logic [MS_W-1:0] es_ms_bus;
  logic            es_fwd_we;
  logic [4:0]      es_fwd_rd;
  logic [XLEN-1:0] es_fwd_data;
  logic            es_busy;

  ex_stage #(.XLEN(XLEN), .OP_W(OP_W), .DS_W(DS_W), .MS_W(MS_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .ds_es_bus(ds_es_bus),
    .es_allowin(es_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_ms_bus(es_ms_bus),
    .es_fwd_we(es_fwd_we), .es_fwd_rd(es_fwd_rd),
    .es_fwd_data(es_fwd_data), .es_busy(es_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MS_W-1:0] bus;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [XLEN-1:0] model(input int op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    logic [4:0] sh;
    p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return $signed(a) >>> sh;
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      11: return p[31:0];
      12: return p[63:32];
      13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [14:0] oh;
    logic [31:0] st;
    exp_t e;
    oh = (op < 0) ? 15'd0 : (15'd1 << op);
    st = $urandom;
    ds_es_bus      = {CTL, oh, a, b, st, rd};
    ds_to_es_valid = 1'b1;
    e.bus = {CTL, model(op, a, b), st, rd};
    e.lat = (op == 13 || op == 14) ? XLEN + 1 : 0;
    sb.push_back(e);
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    present(op, a, b, rd);
    chk("issue allowin", es_allowin, 1'b1);
    tick();
    ds_to_es_valid = 1'b0;
  endtask

  // Waits (bounded) for the head instruction, checks it, and hands it to MEM.
  // If chain is set, the next instruction is presented on the handoff edge.
  task automatic drain(input string tag, input bit chain, input int nop,
                       input logic [31:0] na, input logic [31:0] nb, input logic [4:0] nrd);
    int   cyc;
    bit   busy_ok;
    exp_t e;
    cyc = 0;
    busy_ok = 1'b1;
    while (!es_to_ms_valid && cyc < 3*XLEN) begin
      if (!(es_busy && !es_allowin)) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, " valid"}, es_to_ms_valid, 1'b1);
    chk({tag, " latency"}, cyc, e.lat);
    chk({tag, " bus"}, es_ms_bus, e.bus);
    chk({tag, " fwd_data"}, es_fwd_data, e.bus[5+XLEN +: XLEN]);
    chk({tag, " fwd_rd"}, es_fwd_rd, e.bus[4:0]);
    chk({tag, " fwd_we"}, es_fwd_we, 1'b1);
    if (e.lat > 0) chk({tag, " busy/stall"}, busy_ok, 1'b1);
    if (chain) begin
      present(nop, na, nb, nrd);
      chk({tag, " handoff allowin"}, es_allowin, 1'b1);
    end
    tick();
    ds_to_es_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " to_ms_valid"}, es_to_ms_valid, 1'b0);
    chk({tag, " busy"}, es_busy, 1'b0);
    chk({tag, " fwd_we"}, es_fwd_we, 1'b0);
    chk({tag, " fwd_rd"}, es_fwd_rd, 5'd0);
    chk({tag, " fwd_data"}, es_fwd_data, 32'd0);
    chk({tag, " ms_bus"}, es_ms_bus, {MS_W{1'b0}});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int          t_op [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 8, 10, 11, 12, -1, 5, 7};
  logic [31:0] t_a  [16] = '{32'h1234_5678, 32'h0000_0000, 32'hF0F0_F0F0, 32'hF0F0_0000,
                             32'hAAAA_5555, 32'h0000_0001, 32'h8000_0000, 32'h8000_00F0,
                             32'h0000_0001, 32'h0000_0001, 32'h1111_1111, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0003, 32'h7FFF_FFFF};
  logic [31:0] t_b  [16] = '{32'h0FED_CBA9, 32'h0000_0001, 32'h0FF0_0FF0, 32'h0000_0F0F,
                             32'hFFFF_0000, 32'h0000_001F, 32'h0000_001F, 32'h0000_0004,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hABCD_E000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0025, 32'h0000_0003};

  initial begin
    exp_t tmp;
    resetn = 1'b0; flush = 1'b0; ms_allowin = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_es_bus = {DS_W{1'b1}};
    tick();
    tick();
    chk_zero("reset");
    chk("reset allowin", es_allowin, 1'b1);
    resetn = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_es_bus = '0;
    tick();

    // Overflowing add
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5);
    drain("add", 1'b0, 0, 0, 0, 0);

    // ALU / multiplier sweep
    for (int i = 0; i < 16; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 5'(i + 1));
      drain($sformatf("op%0d_%0d", t_op[i], i), 1'b0, 0, 0, 0, 0);
    end

    // Divides, including divide by zero
    issue(13, 32'd100, 32'd7, 5'd10);
    drain("divu 100/7", 1'b0, 0, 0, 0, 0);
    issue(14, 32'd100, 32'd7, 5'd11);
    drain("remu 100/7", 1'b0, 0, 0, 0, 0);
    issue(13, 32'h1234_5678, 32'd0, 5'd12);
    drain("divu by 0", 1'b0, 0, 0, 0, 0);
    issue(14, 32'h1234_5678, 32'd0, 5'd13);
    drain("remu by 0", 1'b0, 0, 0, 0, 0);

    // Back-to-back divides
    issue(13, 32'hDEAD_BEEF, 32'h0000_1234, 5'd14);
    drain("b2b first", 1'b1, 14, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15);
    drain("b2b second", 1'b0, 0, 0, 0, 0);

    // MEM back-pressure
    ms_allowin = 1'b0;
    issue(0, 32'h0000_1234, 32'h0000_1111, 5'd7);
    present(1, 32'd5, 32'd3, 5'd9);
    for (int i = 0; i < 5; i++) begin
      chk("stall allowin", es_allowin, 1'b0);
      chk("stall valid", es_to_ms_valid, 1'b1);
      chk("stall bus", es_ms_bus, sb[0].bus);
      tick();
    end
    ms_allowin = 1'b1;
    #1;
    chk("release allowin", es_allowin, 1'b1);
    tick();
    ds_to_es_valid = 1'b0;
    tmp = sb.pop_front();
    drain("after stall", 1'b0, 0, 0, 0, 0);

    // Flush during a divide
    issue(13, 32'd1000, 32'd3, 5'd11);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tmp = sb.pop_back();
    chk("flush to_ms_valid", es_to_ms_valid, 1'b0);
    chk("flush busy", es_busy, 1'b0);
    chk("flush allowin", es_allowin, 1'b1);
    chk("flush fwd_we", es_fwd_we, 1'b0);
    issue(0, 32'd40, 32'd2, 5'd3);
    drain("add after flush", 1'b0, 0, 0, 0, 0);
    issue(13, 32'd1000, 32'd3, 5'd4);
    drain("divu after flush", 1'b0, 0, 0, 0, 0);

    // Flush beats a same-cycle latch
    flush = 1'b1;
    present(0, 32'd1, 32'd2, 5'd3);
    tick();
    flush = 1'b0;
    ds_to_es_valid = 1'b0;
    tmp = sb.pop_back();
    chk("flush drop valid", es_to_ms_valid, 1'b0);

    // Reset mid-divide
    issue(14, 32'd12345, 32'd100, 5'd12);
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    tick();
    tmp = sb.pop_back();
    chk_zero("mid-div reset");
    resetn = 1'b1;
    issue(14, 32'd12345, 32'd100, 5'd13);
    drain("remu after reset", 1'b0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
